// File: rtl/mux32_rr_arbiter.sv
// mux32_rr_arbiter: two-requester round-robin arbiter in front of a shared
// 2:1 mux datapath with a registered output word.
// Each owner gets at most MAX_BURST consecutive beats while the other waits.
// Optional feature macro: MUX_ARB_STATS_EN adds the saturating per-requester
// beat counters beats0/beats1.
module mux32_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [15:0]      beats0,
  output logic [15:0]      beats1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST = 8'(MAX_BURST);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic [7:0] cnt_inc;
  logic       last;
  logic       last_nxt;
  logic       load;
  logic       acc0;
  logic       acc1;
  logic       accept;

`ifdef MUX_ARB_STATS_EN
  // Saturating increment so the counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Handshake decode: the output register may load when empty or draining.
  always_comb begin
    load      = !out_valid || out_ready;
    in1_ready = (state == OWN0) && load;
    in2_ready = (state == OWN1) && load;
    acc0      = in1_valid && in1_ready;
    acc1      = in2_valid && in2_ready;
    accept    = acc0 || acc1;
  end

  // Arbitration: next owner, burst counter and last-owner bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    cnt_inc   = cnt + 8'd1;
    case (state)
      IDLE: begin
        // With both requesting, the requester that did not own last wins.
        if (in1_valid && (!in2_valid || last)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
          cnt_nxt   = 8'd0;
        end else if (in2_valid) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
          cnt_nxt   = 8'd0;
        end
      end
      OWN0: begin
        if (acc0 && (cnt_inc == BURST)) begin
          // Burst used up: hand over if the other side waits, else restart.
          cnt_nxt = 8'd0;
          if (in2_valid) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
          end
        end else if (!in1_valid) begin
          cnt_nxt = 8'd0;
          if (in2_valid) begin
            state_nxt = OWN1;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (acc0) begin
          cnt_nxt = cnt_inc;
        end
      end
      OWN1: begin
        if (acc1 && (cnt_inc == BURST)) begin
          cnt_nxt = 8'd0;
          if (in1_valid) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
          end
        end else if (!in2_valid) begin
          cnt_nxt = 8'd0;
          if (in1_valid) begin
            state_nxt = OWN0;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (acc1) begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Control registers; sel is registered alongside the state it mirrors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= 1'b1;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      sel   <= (state_nxt == OWN1);
    end
  end

  // Output register: load the selected word on accept, drain on consumer take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel ? in2_data : in1_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_STATS_EN
  // Per-requester accepted-beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats0 <= 16'd0;
      beats1 <= 16'd0;
    end else begin
      if (acc0) beats0 <= sat_inc16(beats0);
      if (acc1) beats1 <= sat_inc16(beats1);
    end
  end
`endif

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// tb_mux32_rr_arbiter: scoreboard bench for mux32_rr_arbiter (MAX_BURST 4).
// Expected output words are queued when a scenario is set up and popped as
// the consumer takes each word.
module tb_mux32_rr_arbiter;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in1_valid;
  logic [WIDTH-1:0]  in1_data;
  logic              in1_ready;
  logic              in2_valid;
  logic [WIDTH-1:0]  in2_data;
  logic              in2_ready;
  logic              sel;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
`ifdef MUX_ARB_STATS_EN
  logic [15:0]       beats0;
  logic [15:0]       beats1;
`endif

  mux32_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
    ,
    .beats0    (beats0),
    .beats1    (beats1)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  int          rem1, rem2, idx1, idx2;
  logic [31:0] base1, base2;
  bit          inc1, inc2;
  int          tcount, bp_start, bp_len;
  int          first_hs1, last_hs1, first_hs2, first_out, last_out;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_test();
    rem1 = 0; rem2 = 0; idx1 = 0; idx2 = 0;
    inc1 = 1'b0; inc2 = 1'b0;
    base1 = 32'd0; base2 = 32'd0;
    tcount = 0; bp_start = 0; bp_len = 0;
    first_hs1 = -1; last_hs1 = -1; first_hs2 = -1;
    first_out = -1; last_out = -1;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in1_valid = 1'b0; in2_valid = 1'b0;
    in1_data = '0; in2_data = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One cycle: drive producers/consumer, sample mid-cycle, then cross the edge.
  task automatic tick();
    logic h1, h2, ho;
    in1_valid = (rem1 > 0);
    in1_data  = base1 + (inc1 ? 32'(idx1) : 32'd0);
    in2_valid = (rem2 > 0);
    in2_data  = base2 + (inc2 ? 32'(idx2) : 32'd0);
    out_ready = !((tcount >= bp_start) && (tcount < bp_start + bp_len));
    #1;
    h1 = in1_valid && in1_ready;
    h2 = in2_valid && in2_ready;
    ho = out_valid && out_ready;
    if (h1) begin
      check_val("sel_own0", 32'(sel), 32'd0);
      if (first_hs1 < 0) first_hs1 = tcount;
      last_hs1 = tcount;
    end
    if (h2) begin
      check_val("sel_own1", 32'(sel), 32'd1);
      if (first_hs2 < 0) first_hs2 = tcount;
    end
    if (out_valid && !out_ready) begin
      check_val("stall_ready", 32'({in1_ready, in2_ready}), 32'd0);
      if (exp_q.size() > 0) check_val("stall_hold", out_data, exp_q[0]);
    end
    if (ho) begin
      if (first_out < 0) first_out = tcount;
      last_out = tcount;
      check_val("out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_val("out_data", out_data, exp_q.pop_front());
    end
    @(posedge clk); #1;
    if (h1) begin rem1--; idx1++; end
    if (h2) begin rem2--; idx2++; end
    tcount++;
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || rem1 > 0 || rem2 > 0) && n < max) begin
      tick();
      n++;
    end
    check_val("drain_in_time", 32'(n < max), 32'd1);
    tick();
    tick();
  endtask

  initial begin
    start_test();
    do_reset();

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_sel", 32'(sel), 32'd0);
      check_val("idle_out_valid", 32'(out_valid), 32'd0);
      check_val("idle_ready", 32'({in1_ready, in2_ready}), 32'd0);
    end
    check_val("idle_out_data", out_data, 32'd0);

    // Single requester, constant word
    start_test();
    base1 = 32'hAAAAAAAA;
    rem1  = 6;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'hAAAAAAAA);
    run(40);
    check_val("single_first_ready", 32'(first_hs1), 32'd1);
    check_val("single_first_out", 32'(first_out), 32'd2);
    check_val("single_throughput", 32'(last_out - first_out), 32'd5);
`ifdef MUX_ARB_STATS_EN
    check_val("single_beats0", 32'(beats0), 32'd6);
`endif

    // Contention fairness: bursts of 4 alternate, requester 0 first
    do_reset();
    start_test();
    base1 = 32'hA5A5A5A5;
    base2 = 32'h5A5A5A5A;
    rem1 = 12;
    rem2 = 12;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 4; j++)
        exp_q.push_back((k % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
    run(100);
    check_val("fair_first_ready", 32'(first_hs1), 32'd1);
    check_val("fair_switch", 32'(first_hs2 - first_hs1), 32'd4);
`ifdef MUX_ARB_STATS_EN
    check_val("fair_beats0", 32'(beats0), 32'd12);
    check_val("fair_beats1", 32'(beats1), 32'd12);
`endif

    // Backpressure: out_ready low for 5 cycles mid-burst
    do_reset();
    start_test();
    base1 = 32'h10000000;
    inc1  = 1'b1;
    rem1  = 8;
    bp_start = 4;
    bp_len   = 5;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h10000000 + 32'(i));
    run(60);
    check_val("bp_span", 32'(last_out - first_out), 32'd12);

    // Owner drops: in1 sends 2 words, in2 takes over without passing IDLE
    do_reset();
    start_test();
    base1 = 32'h11110000; inc1 = 1'b1; rem1 = 2;
    base2 = 32'h22220000; inc2 = 1'b1; rem2 = 3;
    for (int i = 0; i < 2; i++) exp_q.push_back(32'h11110000 + 32'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h22220000 + 32'(i));
    run(40);
    check_val("drop_gap", 32'(first_hs2 - last_hs1), 32'd2);
    check_val("drop_idle_sel", 32'(sel), 32'd0);
    check_val("drop_idle_ready", 32'({in1_ready, in2_ready}), 32'd0);

    // Asynchronous reset in the middle of an OWN1 burst
    do_reset();
    start_test();
    base2 = 32'h33330000; inc2 = 1'b1; rem2 = 10;
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h33330000 + 32'(i));
    for (int i = 0; i < 4; i++) tick();
    check_val("pre_rst_sel", 32'(sel), 32'd1);
    check_val("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #2;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_sel", 32'(sel), 32'd0);
    check_val("arst_out_data", out_data, 32'd0);
    check_val("arst_ready", 32'({in1_ready, in2_ready}), 32'd0);
`ifdef MUX_ARB_STATS_EN
    check_val("arst_beats0", 32'(beats0), 32'd0);
    check_val("arst_beats1", 32'(beats1), 32'd0);
`endif
    exp_q.delete();
    rem2 = 0;
    in2_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    tick();
    check_val("post_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("post_rst_sel", 32'(sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
# mux32_rr_arbiter

Two-requester round-robin arbiter that shares one 32-bit 2:1 mux datapath between two producers. It drives the mux select, applies valid/ready handshakes on both inputs and the output, and registers the selected word. It sits in front of any single-consumer resource that two sources must time-share.

## Interface
- WIDTH, 32: data width of each input and of the output.
- MAX_BURST, 4: maximum consecutive accepted beats per grant while the other requester is waiting; legal range 1..255.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in1_valid  input  1  requester 0 has a word.
- in1_data  input  WIDTH  requester 0 word.
- in1_ready  output  1  requester 0 word accepted this cycle.
- in2_valid  input  1  requester 1 has a word.
- in2_data  input  WIDTH  requester 1 word.
- in2_ready  output  1  requester 1 word accepted this cycle.
- sel  output  1  mux select: 0 = in1 path, 1 = in2 path; registered.
- out_valid  output  1  out_data holds a word.
- out_data  output  WIDTH  registered selected word.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- States: IDLE, OWN0, OWN1.
  - sel = 1 only in OWN1.
  - `last` flag records the most recent owner; it resets to 1, so requester 0 wins the first contention.
- Datapath:
  - `load = (!out_valid || out_ready)`.
  - in1_ready = OWN0 && load; in2_ready = OWN1 && load. Both are 0 in IDLE.
  - Beat accepted from requester k when ink_valid && ink_ready; out_data <= mux(sel) word, out_valid <= 1.
  - If out_ready && !accept: out_valid <= 0.
  - If out_valid && !out_ready: out_data and out_valid hold.
- Burst counter `cnt` (8 bits): increments on each accepted beat in OWNk and clears on any state change.
- Transitions, evaluated every edge:
  - IDLE:
    - Only in1_valid -> OWN0.
    - Only in2_valid -> OWN1.
    - Both -> owner is the requester != last.
    - Neither -> stay in IDLE.
  - OWNk, with "other" meaning the other requester's valid:
    - (cnt reaches MAX_BURST on this edge's beat) && other -> OWNother.
    - cnt reaches MAX_BURST && !other -> stay, cnt <= 0.
    - !ink_valid && other -> OWNother.
    - !ink_valid && !other -> IDLE.
    - Otherwise stay.
  - Every entry into OWNk sets last <= k.
- Words are never dropped or duplicated. The input word must stay stable while ink_valid && !ink_ready.

## Timing
- Reset values: state IDLE, sel 0, out_valid 0, out_data 0, in1_ready 0, in2_ready 0, cnt 0, last 1.
- Arbitration bubble: valid first seen in IDLE at cycle n -> grant and ready at n+1 -> out_valid at n+2.
- Latency: accepted beat appears on out_data one cycle after acceptance.
- Throughput: one word per cycle while out_ready stays high.
- Owner switch with the new owner valid costs no idle cycle. The new owner's ready is asserted the cycle after the switching edge.
- Backpressure: while out_ready is low and out_valid is high, ready is 0 and the state holds unless the owner drops valid.
- Reset mid-transfer: all registers return to reset values immediately; any in-flight out_data word is discarded.

## Configuration
- MUX_ARB_STATS_EN.
- Defined:
  - Adds outputs beats0 and beats1 (16 bits each, reset 0).
  - Each counts accepted beats for its requester and saturates at 16'hFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then idle: rst pulsed, no valids -> sel 0, out_valid 0, both ready 0 for 10 cycles.
- Single requester:
  - Stimulus: in1_valid held with data 32'hAAAAAAAA, out_ready 1.
  - Response: ready at cycle 1, out_valid and out_data AAAAAAAA at cycle 2, then one word per cycle.
- Contention fairness:
  - Stimulus: both valid continuously, in1 data A5A5A5A5, in2 data 5A5A5A5A, MAX_BURST 4, out_ready 1.
  - Response: output sequence of 4 × A5A5A5A5 then 4 × 5A5A5A5A, repeating; sel toggles every 4 beats.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles mid-burst.
  - Response: out_data held, ready 0, no word lost; the sequence resumes in order.
- Owner drops:
  - Stimulus: in1 sends 2 words then deasserts while in2 is valid.
  - Response: OWN1 is entered with no bubble; with no valids afterwards, IDLE is reached.
- Async reset mid-burst:
  - Stimulus: rst asserted between clock edges during OWN1.
  - Response: out_valid 0 and sel 0 immediately, before the next edge.
  - With MUX_ARB_STATS_EN defined, beats0 and beats1 read 0.
